// File: rtl/flash_read_responder_if.sv
// flash_read_responder_if: Avalon-MM read-only bus between the responder and the flash controller.
// Signals: read, address, byteenable, burstcount (master -> slave);
//          waitrequest, readdata, readdatavalid (slave -> master).
// Modports: master (the responder side), slave (the flash controller side).
interface flash_read_responder_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic [5:0]        burstcount;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output read, address, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, address, byteenable, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/flash_read_responder.sv
// flash_read_responder: turns a one-word read request into a single Avalon-MM flash read and returns the word.
// Ports: clk, reset_n (async active-low); requester side start_next_flash/read/address/byteenable in,
//        flash_reader_finished/data_in/timeout_err out; flash_mem is the Avalon master port.
// Optional FLASH_READ_CACHE_EN: a one-entry cache answers a repeated request without touching the flash.
module flash_read_responder #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_next_flash,
    input  logic                   read,
    input  logic [ADDR_W-1:0]      address,
    input  logic [3:0]             byteenable,
    output logic                   flash_reader_finished,
    output logic [DATA_W-1:0]      data_in,
    output logic                   timeout_err,
    flash_read_responder_if.master flash_mem
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

    state_t            state, state_nx;
    logic              start_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [CNT_W-1:0]  cnt;
    logic              to_q;
    logic              accept, expired, hit, load, to_nx;
    logic [DATA_W-1:0] data_nx, hit_word;

    // A request is taken only on a rising edge of the start level, so a level held high never retriggers.
    assign accept  = state == IDLE && start_next_flash && !start_d && read;
    assign expired = cnt == CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef FLASH_READ_CACHE_EN
    logic              c_valid;
    logic [ADDR_W-1:0] c_addr;
    logic [3:0]        c_be;
    logic [DATA_W-1:0] c_word;
    logic              fill;

    assign hit      = c_valid && c_addr == address && c_be == byteenable;
    assign hit_word = c_word;
    // Only words that really came from the flash refresh the entry; a cache hit itself does not.
    assign fill     = load && !to_nx && state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_valid <= 1'b0;
            c_addr  <= '0;
            c_be    <= '0;
            c_word  <= '0;
        end else if (load && to_nx) begin
            c_valid <= 1'b0;
        end else if (fill) begin
            c_valid <= 1'b1;
            c_addr  <= addr_q;
            c_be    <= be_q;
            c_word  <= data_nx;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        to_nx    = 1'b0;
        data_nx  = flash_mem.readdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = hit ? DONE : REQ;
                    load     = hit;
                    data_nx  = hit_word;
                end
            end
            REQ: begin
                // Data arriving with the command acceptance wins over an expiring timeout.
                if (!flash_mem.waitrequest && flash_mem.readdatavalid) begin
                    state_nx = DONE;
                    load     = 1'b1;
                end else if (expired) begin
                    state_nx = DONE;
                    load     = 1'b1;
                    to_nx    = 1'b1;
                    data_nx  = '0;
                end else if (!flash_mem.waitrequest) begin
                    state_nx = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flash_mem.readdatavalid) begin
                    state_nx = DONE;
                    load     = 1'b1;
                end else if (expired) begin
                    state_nx = DONE;
                    load     = 1'b1;
                    to_nx    = 1'b1;
                    data_nx  = '0;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            start_d <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            cnt     <= '0;
            to_q    <= 1'b0;
            data_in <= '0;
        end else begin
            state   <= state_nx;
            start_d <= start_next_flash;
            to_q    <= to_nx;
            if (accept) begin
                addr_q <= address;
                be_q   <= byteenable;
            end
            cnt <= accept ? '0 : (state == REQ || state == WAIT_DATA) ? cnt + 1'b1 : cnt;
            if (load) data_in <= data_nx;
        end
    end

    // Bus outputs decode straight from state so an async reset drops the read immediately.
    assign flash_mem.read        = state == REQ;
    assign flash_mem.address     = addr_q;
    assign flash_mem.byteenable  = be_q;
    assign flash_mem.burstcount  = 6'd1;
    assign flash_reader_finished = state == DONE;
    assign timeout_err           = to_q;
endmodule

// File: tb/tb_flash_read_responder.sv
// tb_flash_read_responder: scoreboard bench for flash_read_responder with a small Avalon flash model.
module tb_flash_read_responder;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_next_flash = 1'b0;
    logic          read = 1'b0;
    logic [AW-1:0] address = '0;
    logic [3:0]    byteenable = '0;
    logic          flash_reader_finished, timeout_err;
    logic [DW-1:0] data_in;

    flash_read_responder_if #(.ADDR_W(AW), .DATA_W(DW)) fm ();

    flash_read_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start_next_flash      (start_next_flash),
        .read                  (read),
        .address               (address),
        .byteenable            (byteenable),
        .flash_reader_finished (flash_reader_finished),
        .data_in               (data_in),
        .timeout_err           (timeout_err),
        .flash_mem             (fm)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, fin_cnt = 0, rd_cycles = 0, addr_chg = 0, fin_cyc = 0;
    int stall = 0, pend = 0, lat = 3;
    bit rdv_en = 1'b1;
    logic          prev_rd = 1'b0;
    logic [DW-1:0] word = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [3:0]    rd_be = '0;
    logic [DW:0]   exp_q[$], obs_q[$];

    // One clock: drive the flash model for the new cycle, then record what the DUT shows.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        fm.readdatavalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0 && rdv_en) begin
                fm.readdatavalid = 1'b1;
                fm.readdata = word;
            end
        end
        fm.waitrequest = 1'b0;
        if (fm.read) begin
            if (stall > 0) begin
                fm.waitrequest = 1'b1;
                stall--;
            end else begin
                pend = lat;
            end
            rd_cycles++;
            if (prev_rd && (fm.address != rd_addr || fm.byteenable != rd_be)) addr_chg++;
            rd_addr = fm.address;
            rd_be = fm.byteenable;
        end
        prev_rd = fm.read;
        if (flash_reader_finished) begin
            fin_cnt++;
            fin_cyc = cyc;
            obs_q.push_back({timeout_err, data_in});
        end
    endtask

    task automatic request(input logic [AW-1:0] a, input logic [3:0] b, input logic r, input logic [DW-1:0] w);
        address = a;
        byteenable = b;
        read = r;
        word = w;
        start_next_flash = 1'b1;
    endtask

    task automatic wait_fin(input int bound, output bit ok);
        int f0 = fin_cnt;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (fin_cnt > f0) ok = 1'b1;
        end
    endtask

    task automatic release_start();
        start_next_flash = 1'b0;
        read = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        tests++;
        if (flash_reader_finished !== 1'b0 || timeout_err !== 1'b0 || data_in !== '0) begin
            fails++;
            $display("FAIL reset_outputs: fin=%b to=%b data=%h want 0 0 0", flash_reader_finished, timeout_err, data_in);
        end
        tests++;
        if (fm.read !== 1'b0 || fm.address !== '0 || fm.byteenable !== '0 || fm.burstcount !== 6'd1) begin
            fails++;
            $display("FAIL reset_bus: rd=%b addr=%h be=%h bc=%0d want 0 0 0 1", fm.read, fm.address, fm.byteenable, fm.burstcount);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        int e, r0 = rd_cycles, f0 = fin_cnt;
        logic [DW:0] o, x;
        stall = 0; lat = 3; rdv_en = 1'b1;
        request(23'h00010, 4'hF, 1'b1, 32'hDEADBEEF);
        e = cyc;
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        wait_fin(40, ok);
        start_next_flash = 1'b0;
        repeat (3) step();
        tests++; if (!ok) begin fails++; $display("FAIL basic_finish: no finish within 40 cycles"); end
        tests++; if (fin_cyc !== e + 5) begin fails++; $display("FAIL basic_latency: got cycle %0d want %0d", fin_cyc, e + 5); end
        tests++; if (rd_cycles - r0 !== 1) begin fails++; $display("FAIL basic_read_cycles: got %0d want 1", rd_cycles - r0); end
        tests++; if (rd_addr !== 23'h00010 || rd_be !== 4'hF) begin fails++; $display("FAIL basic_addr: got %h/%h want 000010/f", rd_addr, rd_be); end
        tests++; if (fin_cnt - f0 !== 1) begin fails++; $display("FAIL basic_finish_count: got %0d want 1", fin_cnt - f0); end
        o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
        x = exp_q.pop_front();
        tests++; if (o !== x) begin fails++; $display("FAIL basic_data: got %h want %h", o, x); end
        tests++; if (data_in !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_data_hold: got %h want deadbeef", data_in); end
        release_start();
    endtask

    task automatic test_stall();
        bit ok;
        int e, r0 = rd_cycles, c0 = addr_chg;
        logic [DW:0] o, x;
        stall = 5; lat = 2;
        request(23'h01234, 4'h3, 1'b1, 32'h0BADF00D);
        e = cyc;
        exp_q.push_back({1'b0, 32'h0BADF00D});
        step();
        address = 23'h2AAAA;
        byteenable = 4'hC;
        wait_fin(40, ok);
        start_next_flash = 1'b0;
        tests++; if (!ok || fin_cyc !== e + 9) begin fails++; $display("FAIL stall_latency: got cycle %0d want %0d", fin_cyc, e + 9); end
        tests++; if (rd_cycles - r0 !== 6) begin fails++; $display("FAIL stall_read_cycles: got %0d want 6", rd_cycles - r0); end
        tests++; if (addr_chg - c0 !== 0 || rd_addr !== 23'h01234 || rd_be !== 4'h3) begin
            fails++; $display("FAIL stall_addr_stable: changes=%0d addr=%h be=%h want 0 001234 3", addr_chg - c0, rd_addr, rd_be);
        end
        o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
        x = exp_q.pop_front();
        tests++; if (o !== x) begin fails++; $display("FAIL stall_data: got %h want %h", o, x); end
        release_start();
    endtask

    task automatic test_hold();
        bit ok;
        int f0 = fin_cnt;
        logic [DW:0] o, x;
        stall = 0; lat = 1;
        request(23'h00200, 4'hF, 1'b1, 32'h11112222);
        exp_q.push_back({1'b0, 32'h11112222});
        wait_fin(40, ok);
        repeat (50) step();
        tests++; if (fin_cnt - f0 !== 1) begin fails++; $display("FAIL hold_single_finish: got %0d want 1", fin_cnt - f0); end
        start_next_flash = 1'b0;
        step();
        request(23'h00201, 4'hF, 1'b1, 32'h33334444);
        exp_q.push_back({1'b0, 32'h33334444});
        wait_fin(40, ok);
        tests++; if (!ok || fin_cnt - f0 !== 2) begin fails++; $display("FAIL hold_retrigger: got %0d finishes want 2", fin_cnt - f0); end
        for (int i = 0; i < 2; i++) begin
            o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
            x = exp_q.pop_front();
            tests++; if (o !== x) begin fails++; $display("FAIL hold_data%0d: got %h want %h", i, o, x); end
        end
        release_start();
    endtask

    task automatic test_read0();
        int r0 = rd_cycles, f0 = fin_cnt;
        request(23'h00300, 4'hF, 1'b0, 32'h55555555);
        repeat (10) step();
        tests++; if (rd_cycles - r0 !== 0 || fin_cnt - f0 !== 0) begin
            fails++; $display("FAIL read0_ignored: reads=%0d finishes=%0d want 0 0", rd_cycles - r0, fin_cnt - f0);
        end
        release_start();
    endtask

    task automatic test_timeout();
        bit ok;
        int e, f0 = fin_cnt;
        logic [DW:0] o, x;
        stall = 0; lat = 2; rdv_en = 1'b0;
        request(23'h00400, 4'hF, 1'b1, 32'hCAFEF00D);
        e = cyc;
        exp_q.push_back({1'b1, {DW{1'b0}}});
        wait_fin(40, ok);
        start_next_flash = 1'b0;
        tests++; if (!ok || fin_cyc !== e + 1 + TO) begin fails++; $display("FAIL timeout_latency: got cycle %0d want %0d", fin_cyc, e + 1 + TO); end
        o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
        x = exp_q.pop_front();
        tests++; if (o !== x) begin fails++; $display("FAIL timeout_flag_data: got %h want %h", o, x); end
        step();
        fm.readdatavalid = 1'b1;
        fm.readdata = 32'h12345678;
        repeat (4) step();
        tests++; if (fin_cnt - f0 !== 1 || data_in !== '0) begin
            fails++; $display("FAIL timeout_late_data: finishes=%0d data=%h want 1 0", fin_cnt - f0, data_in);
        end
        rdv_en = 1'b1;
        release_start();
    endtask

    task automatic test_cache();
        bit ok;
        int e, r0, f0 = fin_cnt;
        logic [DW:0] o, x;
        stall = 0; lat = 3;
        request(23'h7FFFF, 4'hF, 1'b1, 32'hA5A50001);
        exp_q.push_back({1'b0, 32'hA5A50001});
        wait_fin(40, ok);
        release_start();
        r0 = rd_cycles;
        request(23'h7FFFF, 4'hF, 1'b1, 32'h5A5A0002);
        e = cyc;
`ifdef FLASH_READ_CACHE_EN
        exp_q.push_back({1'b0, 32'hA5A50001});
`else
        exp_q.push_back({1'b0, 32'h5A5A0002});
`endif
        wait_fin(40, ok);
        start_next_flash = 1'b0;
        repeat (2) step();
`ifdef FLASH_READ_CACHE_EN
        tests++; if (rd_cycles - r0 !== 0 || fin_cyc !== e + 1) begin
            fails++; $display("FAIL cache_hit: reads=%0d cycle=%0d want 0 %0d", rd_cycles - r0, fin_cyc, e + 1);
        end
`else
        tests++; if (rd_cycles - r0 !== 1 || fin_cyc !== e + 5) begin
            fails++; $display("FAIL cache_off: reads=%0d cycle=%0d want 1 %0d", rd_cycles - r0, fin_cyc, e + 5);
        end
`endif
        tests++; if (fin_cnt - f0 !== 2) begin fails++; $display("FAIL cache_finishes: got %0d want 2", fin_cnt - f0); end
        for (int i = 0; i < 2; i++) begin
            o = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
            x = exp_q.pop_front();
            tests++; if (o !== x) begin fails++; $display("FAIL cache_data%0d: got %h want %h", i, o, x); end
        end
        release_start();
    endtask

    task automatic test_reset_mid();
        int f0 = fin_cnt;
        stall = 0; lat = 10;
        request(23'h00055, 4'hF, 1'b1, 32'h77778888);
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        tests++; if (fm.read !== 1'b0 || flash_reader_finished !== 1'b0 || timeout_err !== 1'b0 || data_in !== '0 || fm.address !== '0) begin
            fails++; $display("FAIL midreset_outputs: rd=%b fin=%b to=%b data=%h addr=%h want all 0", fm.read, flash_reader_finished, timeout_err, data_in, fm.address);
        end
        start_next_flash = 1'b0;
        read = 1'b0;
        pend = 0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (15) step();
        tests++; if (fin_cnt - f0 !== 0 || obs_q.size() !== 0) begin
            fails++; $display("FAIL midreset_no_finish: got %0d finishes want 0", fin_cnt - f0);
        end
    endtask

    initial begin
        fm.waitrequest = 1'b0;
        fm.readdata = '0;
        fm.readdatavalid = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_hold();
        test_read0();
        test_timeout();
        test_cache();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
